div_reconstruct: RTL and testbench

- Sequential shift-and-add inverse of the restoring divider: takes a quotient, divisor and remainder and rebuilds the dividend as quot*divisor + rem.
- Uses the divider's start/valid handshake, so the two can be chained back-to-back in self-checking datapaths and benches.
- Optional hardware check flags illegal remainder/divisor pairs.

---
 rtl/div_reconstruct.sv | 121 ++++++++++++
 tb/tb_div_reconstruct.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct.sv
// Sequential shift-and-add reconstruction of a dividend: quot*divisor + rem.
// Define DIV_RECON_CHECK_EN to flag illegal remainder/divisor pairs on err.
module div_reconstruct #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   quot,
   input  logic [N-1:0]   divisor,
   input  logic [N-1:0]   rem,
   output logic           busy,
   output logic           valid,
   output logic [2*N-1:0] dividend,
   output logic           err
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   state_t         state_q, state_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [2*N-1:0] mcand_q, mcand_d;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] dividend_q, dividend_d;
   logic           valid_q, valid_d;
   logic [2*N-1:0] sum;

`ifdef DIV_RECON_CHECK_EN
   logic bad_q, bad_d;
   logic err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      valid_d    = 1'b0;
`ifdef DIV_RECON_CHECK_EN
      bad_d      = bad_q;
      err_d      = err_q;
`endif
      sum = mplier_q[0] ? acc_q + mcand_q : acc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d    = {{N{1'b0}}, rem};
               mcand_d  = {{N{1'b0}}, divisor};
               mplier_d = quot;
               cnt_d    = CW'(N);
               state_d  = MUL;
`ifdef DIV_RECON_CHECK_EN
               // Judged on the operands as accepted, not as they drift later.
               bad_d    = (divisor == '0) || (rem >= divisor);
`endif
            end
         end
         MUL: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               dividend_d = sum;
               valid_d    = 1'b1;
               state_d    = IDLE;
`ifdef DIV_RECON_CHECK_EN
               err_d      = bad_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         dividend_q <= '0;
         valid_q    <= 1'b0;
`ifdef DIV_RECON_CHECK_EN
         bad_q      <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         valid_q    <= valid_d;
`ifdef DIV_RECON_CHECK_EN
         bad_q      <= bad_d;
         err_q      <= err_d;
`endif
      end
   end

   assign busy     = (state_q == MUL);
   assign valid    = valid_q;
   assign dividend = dividend_q;
`ifdef DIV_RECON_CHECK_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_div_reconstruct.sv
// Directed bench for div_reconstruct: vector table plus hand-built
// back-to-back, held-start and mid-operation reset sequences.
module tb_div_reconstruct;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   quot, divisor, rem;
   logic           busy, valid, err;
   logic [2*N-1:0] dividend;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0]   q;
      logic [N-1:0]   d;
      logic [N-1:0]   r;
      logic [2*N-1:0] exp;
      logic           e;
   } vec_t;

   vec_t tbl[8];

   div_reconstruct #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .quot(quot), .divisor(divisor), .rem(rem),
      .busy(busy), .valid(valid), .dividend(dividend), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic exp_err(input logic e);
`ifdef DIV_RECON_CHECK_EN
      return e;
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_op(input string nm, input vec_t v);
      int lat, bcnt, vcnt;
      logic [2*N-1:0] got_d;
      logic got_e;
      lat = -1; bcnt = 0; vcnt = 0; got_d = '0; got_e = 1'b0;
      @(negedge clk);
      quot = v.q; divisor = v.d; rem = v.r; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= N + 2; c++) begin
         if (c > 0) begin
            @(posedge clk);
            @(negedge clk);
         end
         if (busy) bcnt++;
         if (valid) begin
            vcnt++;
            if (lat < 0) begin
               lat = c; got_d = dividend; got_e = err;
            end
         end
      end
      chk({nm, "_latency"}, lat, N);
      chk({nm, "_busy_cycles"}, bcnt, N);
      chk({nm, "_valid_pulses"}, vcnt, 1);
      chk({nm, "_dividend"}, got_d, v.exp);
      chk({nm, "_err"}, got_e, exp_err(v.e));
   endtask

   initial begin
      int lat, vcnt;
      tbl[0] = '{q: 4'd1,  d: 4'd8,  r: 4'd7,  exp: 8'd15,  e: 1'b0};
      tbl[1] = '{q: 4'd15, d: 4'd15, r: 4'd15, exp: 8'd240, e: 1'b1};
      tbl[2] = '{q: 4'd0,  d: 4'd0,  r: 4'd0,  exp: 8'd0,   e: 1'b1};
      tbl[3] = '{q: 4'd1,  d: 4'd3,  r: 4'd3,  exp: 8'd6,   e: 1'b1};
      tbl[4] = '{q: 4'd1,  d: 4'd3,  r: 4'd2,  exp: 8'd5,   e: 1'b0};
      tbl[5] = '{q: 4'd5,  d: 4'd2,  r: 4'd0,  exp: 8'd10,  e: 1'b0};
      tbl[6] = '{q: 4'd0,  d: 4'd9,  r: 4'd4,  exp: 8'd4,   e: 1'b0};
      tbl[7] = '{q: 4'd12, d: 4'd11, r: 4'd10, exp: 8'd142, e: 1'b0};

      rst = 1'b1; start = 1'b0; quot = '0; divisor = '0; rem = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid, 0);
      chk("reset_dividend", dividend, 0);
      chk("reset_err", err, 0);

      // back-to-back: second start lands in the valid cycle
      quot = 4'd1; divisor = 4'd8; rem = 4'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy_start", busy, 1);
      for (int c = 1; c <= N; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == N - 1) chk("b2b_dividend_hold", dividend, 0);
         if (c < N) chk("b2b_no_early_valid", valid, 0);
      end
      chk("b2b_first_valid", valid, 1);
      chk("b2b_first_dividend", dividend, 15);
      chk("b2b_first_err", err, 0);
      quot = 4'd5; divisor = 4'd2; rem = 4'd0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_valid_drop", valid, 0);
      chk("b2b_accepted", busy, 1);
      lat = -1; vcnt = 0;
      for (int c = 1; c <= N + 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid) begin
            vcnt++;
            if (lat < 0) begin
               lat = c;
               chk("b2b_second_dividend", dividend, 10);
            end
         end
      end
      chk("b2b_second_latency", lat, N);
      chk("b2b_second_pulses", vcnt, 1);

      foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

      // start held high for ten edges; operands change after acceptance
      @(negedge clk);
      quot = 4'd3; divisor = 4'd4; rem = 4'd1; start = 1'b1;
      for (int c = 0; c <= 13; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 0) begin
            quot = 4'd9; divisor = 4'd9; rem = 4'd9;
         end
         if (c == 9) start = 1'b0;
         chk($sformatf("hold_valid_c%0d", c), valid,
             (c == 4 || c == 9) ? 1 : 0);
         if (c == 4) chk("hold_first_dividend", dividend, 13);
         if (c == 5) chk("hold_reaccept_busy", busy, 1);
         if (c == 9) chk("hold_second_dividend", dividend, 90);
      end

      // reset two cycles into an operation
      @(negedge clk);
      quot = 4'd7; divisor = 4'd7; rem = 4'd0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid, 0);
      chk("abort_dividend", dividend, 0);
      vcnt = 0;
      for (int c = 0; c < N + 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid) vcnt++;
      end
      chk("abort_no_valid", vcnt, 0);
      run_op("after_abort", '{q: 4'd2, d: 4'd3, r: 4'd1, exp: 8'd7, e: 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
